// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer: fetch, decode, execute, memory and write-back control for the 16-bit CPU.
// Latency: 3 cycles (branch/jump/nop), 4 (ALU/imm/store), 5 (load) with zero-wait memories.
// Backpressure: FETCH stalls while imem_ready is low; MEM stalls while dmem_ready is low.
module multicycle_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      ir,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  input  logic             zero,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Opcodes carried in ir[15:12]
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_ADDI  = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_BEQ   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1010;
  localparam logic [3:0] OP_BNE   = 4'b1011;
  localparam logic [3:0] OP_NOP   = 4'b1100;
  localparam logic [3:0] OP_LDI   = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam logic [3:0] OP_ILL   = 4'b1111;

  // ALU function codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;

  // Write-back and PC source selects
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_ABS  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] opcode;
  logic [1:0] imm_src_dec;
  logic       is_mem_op;
  logic       is_pc_only;

  assign opcode = ir[15:12];

  // Opcode classes used by the sequencer: memory ops and ops that retire straight from EXEC
  always_comb begin
    is_mem_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    is_pc_only = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                 (opcode == OP_JMP) || (opcode == OP_NOP);
  end

  // Immediate-format select for the opcode in ir, captured during DECODE
  always_comb begin
    imm_src_dec = 2'b00;
    case (opcode)
      OP_JMP, OP_LDI:                     imm_src_dec = 2'b00;
      OP_LOAD, OP_STORE, OP_BEQ, OP_BNE:  imm_src_dec = 2'b01;
      OP_SHL, OP_SHR:                     imm_src_dec = 2'b10;
      OP_ADDI:                            imm_src_dec = 2'b11;
      default:                            imm_src_dec = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Instruction register: captured on the accepted fetch beat only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     ir <= 16'h0000;
    else if (state_q == S_FETCH && imem_ready)   ir <= imem_rdata;
  end

  // Immediate select register: loaded in DECODE, held until the next DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      imm_src <= 2'b00;
    else if (state_q == S_DECODE) imm_src <= imm_src_dec;
  end

  // Retired-instruction counter: one count per PC update, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired <= '0;
    else if (pc_write) retired <= retired + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT)     state_d = S_HALT;
        else if (opcode == OP_ILL) state_d = S_TRAP;
        else                       state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_pc_only)     state_d = S_FETCH;
        else if (is_mem_op) state_d = S_MEM;
        else                state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) state_d = (opcode == OP_STORE) ? S_FETCH : S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode: strobes and selects from state and ir (ready/zero only where they qualify a strobe)
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    wb_sel      = WB_ALU;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      // Reset holds the request low so the first fetch appears after rst drops
      S_FETCH: imem_req = ~rst;
      S_EXEC: begin
        case (opcode)
          OP_SUB, OP_BEQ, OP_BNE: alu_op = ALU_SUB;
          OP_AND:                 alu_op = ALU_AND;
          OP_OR:                  alu_op = ALU_OR;
          OP_SHL:                 alu_op = ALU_SHL;
          OP_SHR:                 alu_op = ALU_SHR;
          default:                alu_op = ALU_ADD;
        endcase
        alu_src_imm = (opcode == OP_SHL) || (opcode == OP_SHR) ||
                      (opcode == OP_ADDI) || is_mem_op;
        case (opcode)
          OP_BEQ: begin
            pc_write = 1'b1;
            pc_src   = zero ? PC_REL : PC_INC;
          end
          OP_BNE: begin
            pc_write = 1'b1;
            pc_src   = zero ? PC_INC : PC_REL;
          end
          OP_JMP: begin
            pc_write = 1'b1;
            pc_src   = PC_ABS;
          end
          OP_NOP: begin
            pc_write = 1'b1;
            pc_src   = PC_INC;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        // A store retires on its completing beat; a load retires in WB
        if (opcode == OP_STORE && dmem_ready) pc_write = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (opcode)
          OP_LOAD: wb_sel = WB_MEM;
          OP_LDI:  wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
      end
      S_HALT:  halted  = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: randomized and directed instruction streams vs a per-instruction timeline model.
// Each instruction's expected cycle-by-cycle strobes are derived from its opcode class and memory wait counts.
// Ready/zero inputs are randomized wherever the controller must ignore them.
module tb_multicycle_control_unit;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req;
  logic             imem_ready;
  logic [15:0]      imem_rdata;
  logic [15:0]      ir;
  logic [1:0]       imm_src;
  logic [2:0]       alu_op;
  logic             alu_src_imm;
  logic             zero;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .imm_src(imm_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .zero(zero), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  int unsigned      n_cmp = 0;
  int unsigned      n_err = 0;
  logic [CNT_W-1:0] exp_ret;
  logic [1:0]       prev_imm;
  logic [15:0]      prev_ir;
  logic [3:0]       rop;
  logic [CNT_W-1:0] ret_snap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Opcode property tables
  function automatic logic [2:0] f_alu(input logic [3:0] op);
    case (op)
      4'd1, 4'd9, 4'd11: return 3'd1;
      4'd2: return 3'd2;
      4'd3: return 3'd3;
      4'd4: return 3'd4;
      4'd5: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] f_imm(input logic [3:0] op);
    case (op)
      4'd7, 4'd8, 4'd9, 4'd11: return 2'd1;
      4'd4, 4'd5: return 2'd2;
      4'd6: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic f_srcimm(input logic [3:0] op);
    return (op >= 4'd4 && op <= 4'd8);
  endfunction

  function automatic logic [1:0] f_wbsel(input logic [3:0] op);
    if (op == 4'd7) return 2'd1;
    if (op == 4'd13) return 2'd2;
    return 2'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0; imem_rdata = 16'h0;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_ir", ir, 0);
    chk("rst_imm_src", imm_src, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_selects", {alu_op, wb_sel, pc_src}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = '0; prev_imm = 2'd0; prev_ir = 16'h0;
  endtask

  // Run one instruction: iw fetch wait cycles, dw memory wait cycles, zf<0 means random zero
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input int zf);
    logic [3:0] op;
    logic [1:0] src;
    bit term, mem, wr, last, in_fetch, in_exec, in_mem, taken;
    int after, total, k;
    op   = ins[15:12];
    term = (op >= 4'd14);
    mem  = (op == 4'd7) || (op == 4'd8);
    wr   = (op <= 4'd7) || (op == 4'd13);
    if (term)                                   after = 1;
    else if (op >= 4'd9 && op <= 4'd12)         after = 2;
    else if (op == 4'd8)                        after = 3 + dw;
    else if (op == 4'd7)                        after = 4 + dw;
    else                                        after = 3;
    total = iw + 1 + after;
    for (int c = 0; c < total; c++) begin
      k        = c - (iw + 1);
      in_fetch = (c <= iw);
      in_exec  = (k == 1);
      in_mem   = mem && (k >= 2) && (k <= 2 + dw);
      last     = !term && (c == total - 1);
      imem_ready = (c == iw) ? 1'b1 : ((c < iw) ? 1'b0 : 1'($urandom_range(0, 1)));
      imem_rdata = (c == iw) ? ins : 16'($urandom);
      dmem_ready = in_mem ? (k == 2 + dw) : 1'($urandom_range(0, 1));
      zero       = (in_exec && zf >= 0) ? (zf != 0) : 1'($urandom_range(0, 1));
      #1;
      taken = (op == 4'd9 && zero) || (op == 4'd11 && !zero);
      src   = 2'd0;
      if (last && taken)      src = 2'd1;
      if (last && op == 4'd10) src = 2'd2;
      chk("imem_req", imem_req, in_fetch);
      chk("dmem_req", dmem_req, in_mem);
      chk("dmem_we", dmem_we, in_mem && op == 4'd8);
      chk("pc_write", pc_write, last);
      chk("reg_write", reg_write, last && wr);
      chk("pc_src", pc_src, src);
      chk("wb_sel", wb_sel, (last && wr) ? f_wbsel(op) : 2'd0);
      if (in_exec) begin
        chk("alu_op", alu_op, f_alu(op));
        chk("alu_src_imm", alu_src_imm, f_srcimm(op));
      end
      if (k <= 0) chk("fd_selects", {alu_op, alu_src_imm}, 0);
      chk("imm_src", imm_src, (k >= 1) ? f_imm(op) : prev_imm);
      chk("ir", ir, (k >= 0) ? ins : prev_ir);
      chk("retired", retired, exp_ret);
      chk("flags", {halted, illegal}, 0);
      @(posedge clk); #1;
      if (last) exp_ret++;
    end
    prev_imm = f_imm(op);
    prev_ir  = ins;
    if (term) begin
      for (int c = 0; c < 4; c++) begin
        imem_ready = 1'b1; dmem_ready = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1)); imem_rdata = 16'($urandom);
        #1;
        chk("halted", halted, op == 4'd14);
        chk("illegal", illegal, op == 4'd15);
        chk("term_strobes", {imem_req, pc_write, reg_write, dmem_req, dmem_we}, 0);
        chk("term_retired", retired, exp_ret);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    do_reset();

    // Directed: ADD, zero-wait
    run_instr(16'h0123, 0, 0, -1);
    chk("add_retired", retired, 1);
    // Directed: LOAD with three stalled MEM cycles
    run_instr(16'h7abc, 0, 3, -1);
    // Directed: BEQ taken, BNE not taken, both with zero=1
    ret_snap = retired;
    run_instr(16'h9005, 0, 0, 1);
    run_instr(16'hb005, 0, 0, 1);
    chk("br_retired", retired, ret_snap + 2);
    // Directed: immediate-select sequence
    run_instr(16'ha010, 0, 0, -1);
    run_instr(16'h6111, 0, 0, -1);
    run_instr(16'h4222, 0, 0, -1);
    run_instr(16'hd333, 0, 0, -1);

    // Random legal instruction stream with random memory stalls
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 13));
      run_instr({rop, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Reset during a stalled STORE
    imem_ready = 1'b1; imem_rdata = 16'h8123; dmem_ready = 1'b0;
    #1; @(posedge clk); #1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("st_dmem_req", dmem_req, 1);
    chk("st_dmem_we", dmem_we, 1);
    chk("st_pc_write", pc_write, 0);
    rst = 1'b1;
    #1;
    chk("abort_dmem", {dmem_req, dmem_we}, 0);
    chk("abort_wr", {pc_write, reg_write}, 0);
    chk("abort_retired", retired, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("refetch_req", imem_req, 1);
    chk("refetch_ir", ir, 0);
    exp_ret = '0; prev_imm = 2'd0; prev_ir = 16'h0;
    @(posedge clk); #1;
    run_instr(16'h1456, 1, 0, -1);

    // Illegal opcode traps, halt halts
    run_instr(16'hf000, 1, 0, -1);
    do_reset();
    run_instr(16'h2345, 0, 0, -1);
    run_instr(16'he000, 0, 0, -1);
    do_reset();

    // Counter wrap after 2^CNT_W NOPs
    for (int i = 0; i < (1 << CNT_W); i++) run_instr(16'hc000, 0, 0, -1);
    chk("wrap_retired", retired, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle sequencer for the 16-bit CPU. It fetches each instruction over a ready-handshaked instruction-memory port and latches it into the instruction register. It then steps the datapath through decode, execute, memory and write-back, driving the immediate generator's `ImmSrc` select, ALU controls, data-memory strobes, register-file write and PC update. It sits between the memories and the datapath and is the only block that writes the PC.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input, 1: system clock, rising-edge.
- `rst` input, 1: asynchronous, active-high reset.
- `imem_req` output, 1: instruction fetch request.
- `imem_ready` input, 1: fetch data valid this cycle.
- `imem_rdata` input, 16: fetched instruction.
- `ir` output, 16: latched instruction; feeds the immediate generator and register-file address decode.
- `imm_src` output, 2: `ImmSrc` for the immediate generator.
- `alu_op` output, 3: ADD 000, SUB 001, AND 010, OR 011, SHL 100, SHR 101.
- `alu_src_imm` output, 1: ALU operand B selects the immediate.
- `zero` input, 1: ALU zero flag.
- `dmem_req` output, 1: data-memory access request.
- `dmem_we` output, 1: data-memory write.
- `dmem_ready` input, 1: data-memory access complete.
- `reg_write` output, 1: register-file write enable.
- `wb_sel` output, 2: 00 ALU, 01 memory, 10 immediate.
- `pc_write` output, 1: PC update strobe.
- `pc_src` output, 2: 00 PC+1, 01 PC+imm, 10 imm (jump target).
- `halted` output, 1: sticky; set by HALT.
- `illegal` output, 1: sticky; set by opcode 1111.
- `retired` output, CNT_W: count of `pc_write` pulses, wraps.

## Operation
- Opcode is `ir[15:12]`: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SHL, 0101 SHR, 0110 ADDI, 0111 LOAD, 1000 STORE, 1001 BEQ, 1010 JMP, 1011 BNE, 1100 NOP, 1101 LDI, 1110 HALT, 1111 illegal.
- `imm_src` is a register loaded in DECODE and held until the next DECODE:
  - 00 for JMP/LDI.
  - 01 for LOAD/STORE/BEQ/BNE.
  - 10 for SHL/SHR.
  - 11 for ADDI.
  - 00 for all other opcodes.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH: `imem_req`=1 and held until `imem_ready`. On ready, `ir`<=`imem_rdata` and go to DECODE.
- DECODE: load `imm_src`. Next state: HALT for 1110, TRAP for 1111, otherwise EXEC.
- EXEC: drive `alu_op`. `alu_src_imm`=1 for SHL/SHR/ADDI/LOAD/STORE. ADDI/LOAD/STORE use ADD; BEQ/BNE use SUB.
  - BEQ: `pc_write`=1, `pc_src`=01 if `zero` else 00, then FETCH.
  - BNE: same, with taken when `zero`=0.
  - JMP: `pc_write`=1, `pc_src`=10, then FETCH.
  - NOP: `pc_write`=1, `pc_src`=00, then FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: `dmem_req`=1 and `dmem_we`=(STORE), held until `dmem_ready`.
  - LOAD then goes to WB.
  - STORE pulses `pc_write` (`pc_src`=00) in the ready cycle, then FETCH.
- WB: `reg_write`=1, `pc_write`=1, `pc_src`=00, then FETCH. `wb_sel` is 01 for LOAD, 10 for LDI, 00 otherwise.
- HALT/TRAP: terminal. `halted`/`illegal` = 1. All strobes are 0. Only `rst` exits.
- Exactly one `pc_write` pulse per retired instruction; `retired` increments on it, wrapping at 2^CNT_W.

## Timing
- Reset (async) values:
  - State is FETCH.
  - `ir`, `imm_src`, `alu_op`, `wb_sel`, `pc_src` and `retired` are 0.
  - All strobes, `halted` and `illegal` are 0.
  - `imem_req` rises in the first cycle after `rst` deasserts.
- Assertion of `rst` mid-instruction aborts immediately. No partial write survives: `reg_write`, `dmem_req` and `pc_write` drop asynchronously.
- `alu_op`, `alu_src_imm`, `wb_sel` and `pc_src` are combinational from state and `ir`. They are 0 in FETCH, DECODE, HALT and TRAP.
- With zero-wait memories (ready in the request cycle), cycles per instruction are:
  - R-type/SHIFT/ADDI/LDI: 4.
  - BEQ/BNE/JMP/NOP: 3.
  - STORE: 4.
  - LOAD: 5.
- Each cycle of ready held low adds one cycle.
- `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.
- `zero` is sampled only in EXEC of BEQ/BNE.

## Test plan
- ADD (0x0000-class) with `imem_ready`=1 always -> states FETCH, DECODE, EXEC, WB over 4 cycles. `reg_write` and `pc_write` pulse in cycle 4, `wb_sel`=00, `retired`=1.
- LOAD with `dmem_ready` low for 3 MEM cycles -> `dmem_req` high for 4 cycles with `dmem_we`=0, `imm_src`=01. Then WB with `wb_sel`=01. Total 8 cycles.
- BEQ with `zero`=1, then BNE with `zero`=1 -> `pc_src`=01 then 00. One `pc_write` each, no `reg_write`. `retired` increments by 2.
- JMP, then ADDI, SHL, LDI -> `imm_src` 00, 11, 10, 00. JMP gives `pc_src`=10; LDI gives `wb_sel`=10.
- `rst` pulsed during MEM of a STORE with `dmem_ready`=0 -> `dmem_req`/`dmem_we` drop at once, `retired`=0, refetch starts with `imem_req`=1.
- Opcode 1111 -> `illegal`=1 after DECODE and stays set. Opcode 1110 -> `halted`=1. No further `imem_req` or `pc_write` until reset. Separately, run 65536 NOPs -> `retired` wraps to 0.
